// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation sequencer.
// Holds the operand width, mode encodings, the mode-to-top-bit lookup
// and the controller state encodings.
package mod_exp_ctrl_pkg;

    localparam int MAX_BITS = 256;
    localparam int MAX_REG  = MAX_BITS - 1;
    localparam int CNT_W    = 8;

    // Operand width select, shared with the modular multiplier
    localparam logic [1:0] BITS32  = 2'd0;
    localparam logic [1:0] BITS64  = 2'd1;
    localparam logic [1:0] BITS128 = 2'd2;
    localparam logic [1:0] BITS256 = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_BIT,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_NEXT,
        S_FINAL,
        S_DONE
    } state_e;

    // Index of the most significant exponent bit for a given mode (W-1)
    function automatic logic [CNT_W-1:0] mode_wm1(input logic [1:0] mode);
        logic [CNT_W-1:0] wm1;
        case (mode)
            BITS32:  wm1 = CNT_W'(31);
            BITS64:  wm1 = CNT_W'(63);
            BITS128: wm1 = CNT_W'(127);
            default: wm1 = CNT_W'(255);
        endcase
        return wm1;
    endfunction

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer. Owns the shared modular
// multiplier while busy and feeds it through a start/finished handshake.
// Leading zero exponent bits and the first set bit cost no multiplication:
// one_flag marks that R is still the implicit 1, so the first set bit simply
// loads R with the base.
module mod_exp_ctrl #(
    parameter int MAX_BITS = mod_exp_ctrl_pkg::MAX_BITS,
    parameter int CNT_W    = mod_exp_ctrl_pkg::CNT_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_n,
    input  logic [MAX_BITS-1:0] i_base,
    input  logic [MAX_BITS-1:0] i_exp,
    output logic                o_busy,
    output logic                o_finished,
    output logic                o_err,
    output logic [MAX_BITS-1:0] o_result,
    output logic                o_mul_start,
    output logic [1:0]          o_mul_mode,
    output logic [MAX_BITS-1:0] o_mul_n,
    output logic [MAX_BITS-1:0] o_mul_a,
    output logic [MAX_BITS-1:0] o_mul_b,
    input  logic [MAX_BITS-1:0] i_mul_result,
    input  logic                i_mul_finished
);
    import mod_exp_ctrl_pkg::*;

    state_e              state_q, state_d;
    logic [MAX_BITS-1:0] n_q, base_q, exp_q, r_q, res_q;
    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    idx_q;
    logic                one_q, err_q;
    logic                e_bit, bad_op;

    assign e_bit  = exp_q[idx_q];
    assign bad_op = (n_q == '0) || (base_q >= n_q);

    // Multiplier operands come straight from registers that only change on
    // i_mul_finished, so they stay stable for the whole multiplication.
    assign o_mul_a    = r_q;
    assign o_mul_b    = (state_q == S_MUL_ISSUE || state_q == S_MUL_WAIT) ? base_q : r_q;
    assign o_mul_n    = n_q;
    assign o_mul_mode = mode_q;
    assign o_result   = res_q;
    assign o_err      = (state_q == S_DONE) && err_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        o_busy      = 1'b1;
        o_finished  = 1'b0;
        o_mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = S_CHECK;
            end
            S_CHECK:     state_d = bad_op ? S_DONE : S_BIT;
            S_BIT:       state_d = one_q ? S_NEXT : S_SQ_ISSUE;
            S_SQ_ISSUE: begin
                o_mul_start = 1'b1;
                state_d     = S_SQ_WAIT;
            end
            S_SQ_WAIT:   if (i_mul_finished) state_d = e_bit ? S_MUL_ISSUE : S_NEXT;
            S_MUL_ISSUE: begin
                o_mul_start = 1'b1;
                state_d     = S_MUL_WAIT;
            end
            S_MUL_WAIT:  if (i_mul_finished) state_d = S_NEXT;
            S_NEXT:      state_d = (idx_q == '0) ? S_FINAL : S_BIT;
            S_FINAL:     state_d = S_DONE;
            S_DONE: begin
                o_busy     = 1'b0;
                o_finished = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                o_busy  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, accumulator R, bit index and result register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            n_q    <= '0;
            base_q <= '0;
            exp_q  <= '0;
            mode_q <= '0;
            r_q    <= '0;
            res_q  <= '0;
            idx_q  <= '0;
            one_q  <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    n_q    <= i_n;
                    base_q <= i_base;
                    exp_q  <= i_exp;
                    mode_q <= i_mode;
                end
                S_CHECK: begin
                    one_q <= 1'b1;
                    if (bad_op) begin
                        err_q <= 1'b1;
                        r_q   <= '0;
                        res_q <= '0;
                    end else begin
                        err_q <= 1'b0;
                        r_q   <= MAX_BITS'(1);
                        idx_q <= CNT_W'(mode_wm1(mode_q));
                    end
                end
                S_BIT: if (one_q && e_bit) begin
                    r_q   <= base_q;
                    one_q <= 1'b0;
                end
                S_SQ_WAIT, S_MUL_WAIT: if (i_mul_finished) r_q <= i_mul_result;
                S_NEXT: if (idx_q != '0) idx_q <= idx_q - 1'b1;
                // exp==0 within W: x^0 = 1, except modulo 1 where everything is 0
                S_FINAL: begin
                    if (one_q) begin
                        r_q   <= (n_q > MAX_BITS'(1)) ? MAX_BITS'(1) : '0;
                        res_q <= (n_q > MAX_BITS'(1)) ? MAX_BITS'(1) : '0;
                    end else begin
                        res_q <= r_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural stalling multiplier.
module tb_mod_exp_ctrl;
    import mod_exp_ctrl_pkg::*;

    localparam int MB     = 256;
    localparam int BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [MB-1:0] i_n = '0, i_base = '0, i_exp = '0;
    logic          o_busy, o_finished, o_err, o_mul_start;
    logic [MB-1:0] o_result, o_mul_n, o_mul_a, o_mul_b;
    logic [1:0]    o_mul_mode;
    logic [MB-1:0] mul_res = '0;
    logic          mul_fin = 1'b0;
    logic          spur_fin = 1'b0;
    logic          mul_finished;

    assign mul_finished = mul_fin | spur_fin;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.MAX_BITS(MB), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_mode(i_mode),
        .i_n(i_n), .i_base(i_base), .i_exp(i_exp),
        .o_busy(o_busy), .o_finished(o_finished), .o_err(o_err), .o_result(o_result),
        .o_mul_start(o_mul_start), .o_mul_mode(o_mul_mode), .o_mul_n(o_mul_n),
        .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .i_mul_result(mul_res), .i_mul_finished(mul_finished)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [MB-1:0] mulmod(input logic [MB-1:0] a, b, n);
        logic [2*MB-1:0] p;
        p = {{MB{1'b0}}, a} * {{MB{1'b0}}, b};
        p = p % {{MB{1'b0}}, n};
        return p[MB-1:0];
    endfunction

    // Right-to-left reference, independent of the DUT's scan order
    function automatic logic [MB-1:0] gold(input logic [1:0] mode, input logic [MB-1:0] n, base, exp);
        logic [MB-1:0] r, b;
        int w;
        w = (mode == BITS32) ? 32 : (mode == BITS64) ? 64 : (mode == BITS128) ? 128 : 256;
        r = (n > 1) ? MB'(1) : '0;
        b = base;
        for (int i = 0; i < w; i++) begin
            if (exp[i]) r = mulmod(r, b, n);
            b = mulmod(b, b, n);
        end
        return r;
    endfunction

    function automatic logic [MB-1:0] rnd();
        logic [MB-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Behavioural multiplier: random stall, captures operands at start
    int            dly_min = 0, dly_max = 2;
    int            mul_starts = 0, stab_viol = 0;
    bit            pending = 1'b0;
    int            cnt = 0;
    logic [MB-1:0] cap_a, cap_b, cap_n;
    logic [1:0]    cap_mode;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            mul_fin <= 1'b0;
        end else begin
            mul_fin <= 1'b0;
            if (pending) begin
                if (o_mul_a !== cap_a || o_mul_b !== cap_b || o_mul_n !== cap_n || o_mul_mode !== cap_mode)
                    stab_viol <= stab_viol + 1;
                if (cnt == 0) begin
                    mul_fin <= 1'b1;
                    mul_res <= mulmod(cap_a, cap_b, cap_n);
                    pending <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (o_mul_start) begin
                pending    <= 1'b1;
                cnt        <= int'($urandom_range(dly_max, dly_min));
                cap_a      <= o_mul_a;
                cap_b      <= o_mul_b;
                cap_n      <= o_mul_n;
                cap_mode   <= o_mul_mode;
                mul_starts <= mul_starts + 1;
            end
        end
    end

    // Results of the last operation
    logic [MB-1:0] r_res;
    logic          r_err, r_busy1, r_busyfin;
    int            r_muls, r_cyc, r_stab;

    // Launch one operation and wait for o_finished. spur_at / restart_at
    // inject a stray multiplier pulse / a re-start request at that cycle.
    task automatic run_op(input logic [1:0] mode, input logic [MB-1:0] n, base, exp,
                          input int spur_at, input int restart_at);
        int s0, v0;
        bit done;
        s0 = mul_starts;
        v0 = stab_viol;
        @(negedge clk);
        i_mode = mode; i_n = n; i_base = base; i_exp = exp; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        r_busy1 = o_busy;
        r_cyc = 0;
        done = 1'b0;
        while (!done && r_cyc < BUDGET) begin
            if (o_finished) begin
                done = 1'b1;
            end else begin
                spur_fin = (r_cyc == spur_at);
                if (r_cyc == restart_at) begin
                    i_n = 97; i_base = 5; i_exp = 3; i_mode = BITS32; i_start = 1'b1;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge clk);
                r_cyc++;
            end
        end
        spur_fin  = 1'b0;
        i_start   = 1'b0;
        r_res     = o_result;
        r_err     = o_err;
        r_busyfin = o_busy;
        @(negedge clk);
        r_muls = mul_starts - s0;
        r_stab = stab_viol - v0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: no o_finished within %0d cycles", BUDGET);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_finished, o_err, o_mul_start, o_mul_mode} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {o_busy, o_finished, o_err, o_mul_start, o_mul_mode});
        end
        checks++;
        if ((o_result | o_mul_a | o_mul_b | o_mul_n) !== '0) begin
            errors++; $display("FAIL reset_data: got %0h expected 0", o_result | o_mul_a | o_mul_b | o_mul_n);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_op(BITS32, 97, 5, 3, -1, -1);
        checks++; if (r_res !== 28) begin errors++; $display("FAIL basic_5^3_res: got %0d expected 28", r_res); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL basic_5^3_err: got %b expected 0", r_err); end
        checks++; if (r_muls !== 2) begin errors++; $display("FAIL basic_5^3_muls: got %0d expected 2", r_muls); end
        checks++; if ({r_busy1, r_busyfin} !== 2'b10) begin errors++; $display("FAIL basic_busy: got %b expected 10", {r_busy1, r_busyfin}); end
        run_op(BITS32, 1000, 2, 10, -1, -1);
        checks++; if (r_res !== 24) begin errors++; $display("FAIL basic_2^10_res: got %0d expected 24", r_res); end
        checks++; if (r_muls !== 4) begin errors++; $display("FAIL basic_2^10_muls: got %0d expected 4", r_muls); end
    endtask

    task automatic test_stall();
        dly_min = 0; dly_max = 50;
        for (int k = 0; k < 3; k++) begin
            run_op(BITS32, 1000, 2, 10, -1, -1);
            checks++; if (r_res !== 24) begin errors++; $display("FAIL stall_res: got %0d expected 24", r_res); end
            checks++; if (r_muls !== 4) begin errors++; $display("FAIL stall_muls: got %0d expected 4", r_muls); end
            checks++; if (r_stab !== 0) begin errors++; $display("FAIL stall_stable: got %0d expected 0", r_stab); end
        end
        dly_max = 2;
    endtask

    task automatic test_exp_zero();
        run_op(BITS32, 97, 5, 0, 10, -1);
        checks++; if (r_res !== 1) begin errors++; $display("FAIL exp0_res: got %0d expected 1", r_res); end
        checks++; if (r_cyc !== 66) begin errors++; $display("FAIL exp0_latency: got %0d expected 66", r_cyc); end
        checks++; if (r_muls !== 0) begin errors++; $display("FAIL exp0_muls: got %0d expected 0", r_muls); end
        run_op(BITS32, 1, 0, 0, -1, -1);
        checks++; if (r_res !== 0) begin errors++; $display("FAIL exp0_n1_res: got %0d expected 0", r_res); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL exp0_n1_err: got %b expected 0", r_err); end
    endtask

    task automatic test_errors();
        logic [MB-1:0] ns[3]  = '{MB'(0), MB'(97), MB'(97)};
        logic [MB-1:0] bs[3]  = '{MB'(5), MB'(100), MB'(97)};
        for (int k = 0; k < 3; k++) begin
            run_op(BITS32, 1000, 2, 10, -1, -1);
            run_op(BITS32, ns[k], bs[k], 3, -1, -1);
            checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", k, r_err); end
            checks++; if (r_res !== 0) begin errors++; $display("FAIL err%0d_res: got %0d expected 0", k, r_res); end
            checks++; if (r_muls !== 0) begin errors++; $display("FAIL err%0d_muls: got %0d expected 0", k, r_muls); end
        end
    endtask

    task automatic test_wide();
        logic [MB-1:0] n, b, e, exp_r;
        logic [MB-1:0] hi;
        n = '1;
        n = (n >> 1) - 18;
        run_op(BITS256, n, 2, n - 1, -1, -1);
        checks++; if (r_res !== 1) begin errors++; $display("FAIL fermat_res: got %0h expected 1", r_res); end
        hi = '0;
        hi[200] = 1'b1;
        run_op(BITS64, 97, 5, hi | 3, -1, -1);
        checks++; if (r_res !== 28) begin errors++; $display("FAIL mode64_upper_res: got %0d expected 28", r_res); end
        hi = '0;
        hi[40] = 1'b1;
        run_op(BITS32, 1000, 2, hi | 10, -1, -1);
        checks++; if (r_res !== 24) begin errors++; $display("FAIL mode32_upper_res: got %0d expected 24", r_res); end
        for (int k = 0; k < 4; k++) begin
            logic [1:0] m;
            m = (k < 2) ? BITS256 : BITS64;
            n = rnd() | MB'(1);
            b = rnd() % n;
            e = rnd();
            exp_r = gold(m, n, b, e);
            run_op(m, n, b, e, -1, -1);
            checks++; if (r_res !== exp_r) begin errors++; $display("FAIL rand%0d_res: got %0h expected %0h", k, r_res, exp_r); end
            checks++; if (r_stab !== 0) begin errors++; $display("FAIL rand%0d_stable: got %0d expected 0", k, r_stab); end
        end
    endtask

    task automatic test_back_to_back();
        dly_min = 3; dly_max = 5;
        run_op(BITS32, 1000, 2, 10, -1, 5);
        checks++; if (r_res !== 24) begin errors++; $display("FAIL restart_res: got %0d expected 24", r_res); end
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b expected 0", o_busy); end
        run_op(BITS32, 97, 5, 3, -1, -1);
        checks++; if (r_res !== 28) begin errors++; $display("FAIL b2b_res: got %0d expected 28", r_res); end
        dly_min = 0; dly_max = 2;
    endtask

    task automatic test_reset_mid();
        int  w;
        bit  seen_fin;
        dly_min = 30; dly_max = 30;
        @(negedge clk);
        i_mode = BITS32; i_n = 1000; i_base = 2; i_exp = 10; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        w = 0;
        while (!o_mul_start && w < 200) begin @(negedge clk); w++; end
        checks++; if (o_mul_start !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got %b expected 1", o_mul_start); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_finished, o_err, o_mul_start, o_mul_mode} !== 6'd0) begin
            errors++; $display("FAIL rstmid_ctrl: got %b expected 0", {o_busy, o_finished, o_err, o_mul_start, o_mul_mode});
        end
        checks++;
        if ((o_result | o_mul_a | o_mul_b | o_mul_n) !== '0) begin
            errors++; $display("FAIL rstmid_data: got %0h expected 0", o_result | o_mul_a | o_mul_b | o_mul_n);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen_fin = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_finished || o_busy) seen_fin = 1'b1;
        end
        checks++; if (seen_fin !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %b expected 0", seen_fin); end
        dly_min = 0; dly_max = 2;
        run_op(BITS32, 1000, 2, 10, -1, -1);
        checks++; if (r_res !== 24) begin errors++; $display("FAIL rstmid_rerun: got %0d expected 24", r_res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_exp_zero();
        test_errors();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
